// File: rtl/operand_reader.sv
// Register-read stage: resolves source operands from the register file or the
// retiring writeback value, tracks pending writes per register, issues to execute.
module operand_reader #(
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_w_rd,
  input  logic [31:0] regs [32],
  input  logic        ret_valid,
  input  logic [4:0]  ret_rd,
  input  logic        ret_commit,
  input  logic [31:0] ret_res,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_rd,
  output logic        out_w_rd
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend     [32];
  logic [PEND_W-1:0] pend_nxt [32];
  logic [1:0]        dec_v    [32];
  logic [31:0]       inc_v;
  logic [31:0]       uflow;

  logic [32:0] src1_p0;
  logic [32:0] src2_p0;
  logic        rd_full_p0;
  logic        stall_p0;
  logic        accept_p0;

  logic        vld_p1;
  logic [31:0] pc_p1;
  logic [31:0] a_p1;
  logic [31:0] b_p1;
  logic [4:0]  rd_p1;
  logic        w_rd_p1;

  // Returns {resolved, value}; value is only meaningful when resolved is set.
  function automatic logic [32:0] resolve(
    input logic [4:0]        rs,
    input logic [PEND_W-1:0] cnt,
    input logic [31:0]       rf_val,
    input logic              rv,
    input logic [4:0]        rrd,
    input logic              rcommit,
    input logic [31:0]       rres
  );
    if (rs == 5'd0)
      return {1'b1, 32'd0};
    if (cnt == '0)
      return {1'b1, rf_val};
    if (cnt == PEND_W'(1) && rv && rrd == rs)
      return {1'b1, rcommit ? rres : rf_val};
    return {1'b0, rf_val};
  endfunction

  // Applies an increment and up to two decrements, clamped to [0, PEND_MAX].
  function automatic logic [PEND_W-1:0] pend_step(
    input logic [PEND_W-1:0] cur,
    input logic              inc,
    input logic [1:0]        dec
  );
    logic [PEND_W+1:0] sum;
    sum = {2'b00, cur} + {{(PEND_W+1){1'b0}}, inc};
    if (sum <= {{PEND_W{1'b0}}, dec})
      return '0;
    sum = sum - {{PEND_W{1'b0}}, dec};
    if (sum > {2'b00, PEND_MAX})
      return PEND_MAX;
    return sum[PEND_W-1:0];
  endfunction

  function automatic logic pend_uflow(
    input logic [PEND_W-1:0] cur,
    input logic              inc,
    input logic [1:0]        dec
  );
    return ({2'b00, cur} + {{(PEND_W+1){1'b0}}, inc}) < {{PEND_W{1'b0}}, dec};
  endfunction

  // ---- stage p0: operand resolution and issue decision ----
  always_comb begin
    src1_p0 = resolve(in_rs1, pend[in_rs1], regs[in_rs1], ret_valid, ret_rd, ret_commit, ret_res);
    src2_p0 = resolve(in_rs2, pend[in_rs2], regs[in_rs2], ret_valid, ret_rd, ret_commit, ret_res);
    rd_full_p0 = in_w_rd && (in_rd != 5'd0) && (pend[in_rd] == PEND_MAX)
                 && !(ret_valid && ret_rd == in_rd);
    stall_p0  = in_valid && (!src1_p0[32] || !src2_p0[32] || rd_full_p0);
    in_ready  = !rst && !flush && !stall_p0 && (!vld_p1 || out_ready);
    accept_p0 = in_valid && in_ready;
  end

  always_comb begin
    inc_v = '0;
    uflow = '0;
    for (int r = 0; r < 32; r++) begin
      dec_v[r]    = 2'd0;
      pend_nxt[r] = '0;
      if (r != 0) begin
        inc_v[r] = accept_p0 && in_w_rd && (in_rd == 5'(r));
        dec_v[r] = {1'b0, ret_valid && (ret_rd == 5'(r))}
                 + {1'b0, flush && vld_p1 && w_rd_p1 && (rd_p1 == 5'(r))};
        pend_nxt[r] = pend_step(pend[r], inc_v[r], dec_v[r]);
        uflow[r]    = pend_uflow(pend[r], inc_v[r], dec_v[r]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++)
        pend[r] <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  // A decrement with nothing pending means writeback or flush retired a phantom write.
  always_ff @(posedge clk) begin
    if (!rst)
      assert (uflow == '0);
  end

  // ---- stage p1: operand bundle register toward execute ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      pc_p1   <= '0;
      a_p1    <= '0;
      b_p1    <= '0;
      rd_p1   <= '0;
      w_rd_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      pc_p1   <= in_pc;
      a_p1    <= src1_p0[31:0];
      b_p1    <= src2_p0[31:0];
      rd_p1   <= in_rd;
      w_rd_p1 <= in_w_rd;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_pc    = pc_p1;
  assign out_a     = a_p1;
  assign out_b     = b_p1;
  assign out_rd    = rd_p1;
  assign out_w_rd  = w_rd_p1;

endmodule
